// File: rtl/multicycle_sequencer_if.sv
// Control bus between the multicycle sequencer and the datapath: instruction fields and
// handshake in, mux/enable strobes out.
interface multicycle_sequencer_if;
  logic [1:0] Op;
  logic       Inmed;
  logic [3:0] func;
  logic       CondEx;
  logic       MemReady;

  logic       MemReq;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       MemtoReg;
  logic       ALUSrc;
  logic       FlagW;
  logic [3:0] ALUControl;
  logic       Fault;

  modport master (
    input  Op, Inmed, func, CondEx, MemReady,
    output MemReq, AdrSrc, IRWrite, PCWrite, PCSrc, RegWrite, MemWrite, MemtoReg,
           ALUSrc, FlagW, ALUControl, Fault
  );

  modport slave (
    output Op, Inmed, func, CondEx, MemReady,
    input  MemReq, AdrSrc, IRWrite, PCWrite, PCSrc, RegWrite, MemWrite, MemtoReg,
           ALUSrc, FlagW, ALUControl, Fault
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control sequencer with memory wait timeout.
// Optional MULTICYCLE_PERF_CNT_EN adds RetireCnt/StallCnt performance counters.
module multicycle_sequencer #(
  parameter int WAIT_MAX = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_sequencer_if.master bus
`ifdef MULTICYCLE_PERF_CNT_EN
  ,
  output logic [15:0]            RetireCnt,
  output logic [15:0]            StallCnt
`endif
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC    = 4'd2,
    S_ALU_WB  = 4'd3,
    S_MEM_ADR = 4'd4,
    S_MEM_RD  = 4'd5,
    S_MEM_WB  = 4'd6,
    S_MEM_WR  = 4'd7,
    S_BRANCH  = 4'd8,
    S_FAULT   = 4'd9
  } state_t;

  localparam logic [3:0] FN_CMP  = 4'b1001;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [8:0] WAIT_LIM = 9'(WAIT_MAX);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_wcnt;
  logic       w_timeout;

  logic       w_memreq, w_adrsrc, w_irwrite, w_pcwrite, w_pcsrc, w_regwrite;
  logic       w_memwrite, w_memtoreg, w_alusrc, w_flagw, w_fault;
  logic [3:0] w_aluctl;

  // Fault when this wait cycle would be the WAIT_MAX-th consecutive one; a ready wins.
  assign w_timeout = ({1'b0, r_wcnt} + 9'd1) >= WAIT_LIM;

  always_comb begin
    w_next     = r_state;
    w_memreq   = 1'b0;
    w_adrsrc   = 1'b0;
    w_irwrite  = 1'b0;
    w_pcwrite  = 1'b0;
    w_pcsrc    = 1'b0;
    w_regwrite = 1'b0;
    w_memwrite = 1'b0;
    w_memtoreg = 1'b0;
    w_alusrc   = 1'b0;
    w_flagw    = 1'b0;
    w_fault    = 1'b0;
    w_aluctl   = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_memreq = 1'b1;
        if (bus.MemReady) begin
          w_irwrite = 1'b1;
          w_pcwrite = 1'b1;
          w_next    = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end
      end
      S_DECODE: begin
        case (bus.Op)
          2'b00:   w_next = S_EXEC;
          2'b11:   w_next = S_BRANCH;
          default: w_next = S_MEM_ADR;
        endcase
      end
      S_EXEC: begin
        w_aluctl = bus.func;
        w_alusrc = bus.Inmed;
        if (bus.func == FN_CMP) begin
          w_flagw = bus.CondEx;
          w_next  = S_FETCH;
        end else begin
          w_next = S_ALU_WB;
        end
      end
      S_ALU_WB: begin
        w_aluctl   = bus.func;
        w_alusrc   = bus.Inmed;
        w_regwrite = bus.CondEx;
        w_next     = S_FETCH;
      end
      S_MEM_ADR: begin
        w_alusrc = bus.Inmed;
        w_next   = (bus.Op == 2'b10) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        w_memreq = 1'b1;
        w_adrsrc = 1'b1;
        if (bus.MemReady)  w_next = S_MEM_WB;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_MEM_WB: begin
        w_memtoreg = 1'b1;
        w_regwrite = bus.CondEx;
        w_next     = S_FETCH;
      end
      S_MEM_WR: begin
        // A condition-failed store never touches memory.
        if (!bus.CondEx) begin
          w_next = S_FETCH;
        end else begin
          w_memreq   = 1'b1;
          w_adrsrc   = 1'b1;
          w_memwrite = 1'b1;
          if (bus.MemReady)  w_next = S_FETCH;
          else if (w_timeout) w_next = S_FAULT;
        end
      end
      S_BRANCH: begin
        w_alusrc  = 1'b1;
        w_pcsrc   = 1'b1;
        w_pcwrite = bus.CondEx;
        w_next    = S_FETCH;
      end
      S_FAULT: w_fault = 1'b1;
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_wcnt  <= 8'd0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state || bus.MemReady) r_wcnt <= 8'd0;
      else if (w_memreq)                     r_wcnt <= r_wcnt + 8'd1;
    end
  end

  assign bus.MemReq     = w_memreq   & ~rst;
  assign bus.AdrSrc     = w_adrsrc   & ~rst;
  assign bus.IRWrite    = w_irwrite  & ~rst;
  assign bus.PCWrite    = w_pcwrite  & ~rst;
  assign bus.PCSrc      = w_pcsrc    & ~rst;
  assign bus.RegWrite   = w_regwrite & ~rst;
  assign bus.MemWrite   = w_memwrite & ~rst;
  assign bus.MemtoReg   = w_memtoreg & ~rst;
  assign bus.ALUSrc     = w_alusrc   & ~rst;
  assign bus.FlagW      = w_flagw    & ~rst;
  assign bus.Fault      = w_fault    & ~rst;
  assign bus.ALUControl = rst ? 4'b0000 : w_aluctl;

`ifdef MULTICYCLE_PERF_CNT_EN
  logic [15:0] r_retire;
  logic [15:0] r_stall;

  // FAULT has no exits and no requests, so both counters freeze there naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retire <= 16'd0;
      r_stall  <= 16'd0;
    end else begin
      if (w_next == S_FETCH && r_state != S_FETCH) r_retire <= r_retire + 16'd1;
      if (w_memreq && !bus.MemReady && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
    end
  end

  assign RetireCnt = rst ? 16'd0 : r_retire;
  assign StallCnt  = rst ? 16'd0 : r_stall;
`endif

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multicycle control sequencer for the processor's Op/Inmed/func instruction format. It replaces single-cycle control decoding with a state machine that steps each instruction through fetch, decode, execute, memory and writeback. It drives a shared ALU, register file and a single instruction/data memory port using a request/ready handshake. It sits between the instruction register fields and the datapath mux/enable controls.

## Interface
- WAIT_MAX, 15: maximum consecutive cycles with MemReady low before a memory access faults (1..255).
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Op  in  2  opcode: 00 data-processing, 01 LDR, 10 STR, 11 B.
- Inmed  in  1  immediate operand select for Op=00/01.
- func  in  4  ALU function for Op=00; 1001 = CMP.
- CondEx  in  1  condition-pass from the flag/condition unit; valid from DECODE onward.
- MemReady  in  1  memory access complete this cycle.
- MemReq  out  1  memory access request.
- AdrSrc  out  1  0 = PC address, 1 = ALU result address.
- IRWrite  out  1  load instruction register.
- PCWrite  out  1  load PC.
- PCSrc  out  1  0 = PC+4, 1 = branch target.
- RegWrite  out  1  register-file write enable.
- MemWrite  out  1  memory write enable (valid with MemReq).
- MemtoReg  out  1  writeback source: 1 = memory data.
- ALUSrc  out  1  1 = immediate operand B.
- FlagW  out  1  flag register write enable.
- ALUControl  out  4  ALU operation.
- Fault  out  1  sticky memory timeout indication.

## Operation
- States: FETCH, DECODE, EXEC, ALU_WB, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, BRANCH, FAULT.
- FETCH: MemReq=1, AdrSrc=0. Stay in FETCH while MemReady=0. On MemReady=1: IRWrite=1, PCWrite=1, PCSrc=0, then go to DECODE.
- DECODE: no strobes. Next state: Op=00 -> EXEC; 01/10 -> MEM_ADR; 11 -> BRANCH.
- EXEC: ALUControl=func, ALUSrc=Inmed.
  - func=1001 (CMP): FlagW=CondEx, then go to FETCH.
  - All other func values: go to ALU_WB.
- ALU_WB: ALUControl=func, ALUSrc=Inmed, MemtoReg=0, RegWrite=CondEx, then go to FETCH.
- MEM_ADR: ALUControl=0000 (ADD), ALUSrc=Inmed. Next state: Op=01 -> MEM_RD; Op=10 -> MEM_WR.
- MEM_RD: MemReq=1, AdrSrc=1, MemWrite=0. Wait for MemReady, then go to MEM_WB.
- MEM_WB: MemtoReg=1, RegWrite=CondEx, then go to FETCH.
- MEM_WR: MemReq=1, AdrSrc=1, MemWrite=CondEx.
  - If CondEx=0: no request is made (MemReq=0); go to FETCH next cycle.
  - If CondEx=1: wait for MemReady, then go to FETCH.
- BRANCH: ALUControl=0000, ALUSrc=1, PCSrc=1, PCWrite=CondEx, then go to FETCH.
- Wait counter (8 bits):
  - Cleared on entry to any request state and whenever MemReady=1.
  - Increments each cycle MemReq=1 and MemReady=0.
  - When the counter reaches WAIT_MAX while MemReady is still 0, go to FAULT.
- FAULT: all strobes 0, Fault=1. Held until rst.
- Any unlisted state encoding goes to FETCH.

## Timing
- rst sampled high: state becomes FETCH and the wait counter clears on that edge. All outputs read 0 during the reset cycle (gated by rst), including Fault. Reset asserted mid-instruction aborts it with no further strobes.
- All outputs are combinational from state, CondEx and MemReady. State and counter are registered.
- Cycle counts with MemReady=1 on the first request cycle:
  - Data-processing: 4 cycles.
  - CMP: 3 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - B: 3 cycles.
- Each wait cycle in FETCH, MEM_RD or MEM_WR adds one cycle.
- MemReq stays high continuously until the MemReady cycle; it is never dropped mid-wait.
- With WAIT_MAX=N, the FAULT state is entered after N consecutive cycles of MemReady=0 in one request state.
- MemReady=1 on the same cycle the counter reaches WAIT_MAX completes the access; the access does not fault.

## Configuration
- MULTICYCLE_PERF_CNT_EN defined:
  - Adds output RetireCnt (out, 16) and output StallCnt (out, 16), both cleared by rst.
  - RetireCnt increments on every transition into FETCH from a non-FETCH state, including condition-failed instructions, and wraps at 0xFFFF -> 0.
  - StallCnt increments each cycle with MemReq=1 and MemReady=0, and saturates at 0xFFFF.
  - Neither counter increments in FAULT.
- Undefined: neither port exists; behaviour is otherwise identical.

## Test plan
- rst=1 for 2 cycles, then Op=00, func=0000, Inmed=0, CondEx=1, MemReady=1 -> states FETCH, DECODE, EXEC, ALU_WB; RegWrite=1 only in cycle 4; FETCH re-entered in cycle 5.
- CMP (Op=00, func=1001, Inmed=1), CondEx=1 -> FlagW=1 in cycle 3, RegWrite never asserted, back to FETCH in cycle 4.
- LDR (Op=01) with MemReady low for 3 cycles in MEM_RD -> MemReq held for 4 cycles, then MEM_WB with MemtoReg=1 and RegWrite=1; total 8 cycles.
- STR (Op=10) with CondEx=0 -> MemWrite=0 and MemReq=0 in MEM_WR; FETCH next cycle. Repeat with CondEx=1 -> MemWrite=1 for the access cycle.
- B (Op=11) with CondEx=1 -> PCWrite=1, PCSrc=1 in cycle 3. With CondEx=0 -> PCWrite=0 in cycle 3.
- WAIT_MAX=4, MemReady held 0 in FETCH -> FAULT entered after 4 cycles; Fault=1 and all strobes 0 until rst. Assert rst mid-LDR -> FETCH and all outputs 0 after the edge.
